// File: rtl/packet_gen_mp.sv
// packet_gen_mp: multi-pattern AXI-Stream packet generator for cable loopback.
//
// A run begins with a start pulse. The compare FIFO is held in reset for
// RST_CYC cycles and then left to settle for RST_CYC cycles. After that the
// generator emits packets of BEATS_PER_PACKET beats, with GAP_CYCLES idle
// cycles between packets, until PACKET_COUNT packets have been sent or an
// abort takes effect. Every transmitted beat is mirrored, without any
// injected error, onto the compare-FIFO stream.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start, abort           run control pulses
//   mode, PATTERN          pattern select (0 LFSR, 1 counter, 2 fixed, 3 walking-one)
//   BEATS_PER_PACKET       beats per packet (0 means 1)
//   PACKET_COUNT           packets per run (0 means continuous)
//   GAP_CYCLES             idle cycles between packets
//   LAST_KEEP              TKEEP on the last beat (0 means all-ones)
//   sim_err, err_bit       single-bit error injection request
//   busy, packet_sent, done, packets_sent, errs_injected   status
//   resetn_fifo            compare-FIFO reset, active-low
//   AXIS_OUT_*             cable-side stream
//   AXIS_FIFO_*            compare-FIFO mirror stream

// One 32-bit lane of the clean pattern word.
module packet_gen_mp_lane #(
    parameter int LANE      = 0,
    parameter int NUM_LANES = 16,
    parameter int WB        = 9
) (
    input  logic [1:0]    mode,
    input  logic [31:0]   lfsr,
    input  logic [31:0]   beat_idx,
    input  logic [31:0]   pattern,
    input  logic [WB-1:0] walk_pos,
    output logic [31:0]   word
);
    localparam logic [31:0] MIX = 32'(LANE) * 32'h9E37_79B9;

    always_comb begin
        word = '0;
        case (mode)
            2'd0: word = lfsr ^ MIX;
            2'd1: word = beat_idx * 32'(NUM_LANES) + 32'(LANE);
            2'd2: word = pattern;
            default: begin
                // The single set bit lives in this lane only when the
                // upper bits of the walk position select it.
                if (32'(walk_pos >> 5) == 32'(LANE))
                    word = 32'd1 << walk_pos[4:0];
            end
        endcase
    end
endmodule

module packet_gen_mp #(
    parameter int          DW      = 512,
    parameter int          LEN_W   = 16,
    parameter int          GAP_W   = 8,
    parameter int          RST_CYC = 16,
    parameter logic [31:0] SEED    = 32'hACE1_2468
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [31:0]            PATTERN,
    input  logic [LEN_W-1:0]       BEATS_PER_PACKET,
    input  logic [63:0]            PACKET_COUNT,
    input  logic [GAP_W-1:0]       GAP_CYCLES,
    input  logic [DW/8-1:0]        LAST_KEEP,
    input  logic                   sim_err,
    input  logic [$clog2(DW)-1:0]  err_bit,
    output logic                   busy,
    output logic                   packet_sent,
    output logic                   done,
    output logic [63:0]            packets_sent,
    output logic [31:0]            errs_injected,
    output logic                   resetn_fifo,
    output logic [DW-1:0]          AXIS_OUT_TDATA,
    output logic [DW/8-1:0]        AXIS_OUT_TKEEP,
    output logic                   AXIS_OUT_TLAST,
    output logic                   AXIS_OUT_TVALID,
    input  logic                   AXIS_OUT_TREADY,
    output logic [DW-1:0]          AXIS_FIFO_TDATA,
    output logic                   AXIS_FIFO_TVALID,
    input  logic                   AXIS_FIFO_TREADY
);
    localparam int          NUM_LANES = DW / 32;
    localparam int          WB        = $clog2(DW);
    localparam int          KW        = DW / 8;
    localparam logic [31:0] TAPS      = 32'h8020_0003;
    localparam logic [DW-1:0] ONE     = DW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_FIFO_RST, S_FIFO_SETTLE, S_GEN, S_GAP
    } state_t;

    state_t             state, state_n;
    logic [31:0]        cnt;
    logic [1:0]         mode_q;
    logic [31:0]        pattern_q;
    logic [LEN_W-1:0]   beats_q;
    logic [63:0]        count_q;
    logic [GAP_W-1:0]   gap_q;
    logic [KW-1:0]      keep_q;
    logic [31:0]        lfsr;
    logic [31:0]        beat_idx;
    logic [WB-1:0]      walk_pos;
    logic [LEN_W-1:0]   beat_in_pkt;
    logic               abort_pend;
    logic               err_pend;
    logic [WB-1:0]      err_bit_q;

    logic               start_acc, in_gen, tvalid, hs, last_beat, hs_last;
    logic               abort_any, run_end;
    logic [DW-1:0]      clean, flip;
    logic [NUM_LANES-1:0][31:0] lane_word;

    assign start_acc = (state == S_IDLE) & start;
    assign in_gen    = (state == S_GEN);
    // A full compare FIFO holds off the cable side so the mirror never drops a beat.
    assign tvalid    = in_gen & AXIS_FIFO_TREADY;
    assign hs        = tvalid & AXIS_OUT_TREADY;
    assign last_beat = in_gen & (beat_in_pkt == beats_q - LEN_W'(1));
    assign hs_last   = hs & last_beat;
    assign abort_any = abort_pend | abort;
    assign run_end   = (count_q != '0) && (packets_sent + 64'd1 == count_q);

    // ---------------- FSM ----------------
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:        if (start) state_n = S_FIFO_RST;
            S_FIFO_RST:    if (cnt == 32'(RST_CYC - 1)) state_n = S_FIFO_SETTLE;
            S_FIFO_SETTLE: if (cnt == 32'(RST_CYC - 1)) state_n = S_GEN;
            S_GEN: begin
                if (hs_last) begin
                    if (abort_any || run_end) state_n = S_IDLE;
                    else if (gap_q != '0)     state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (abort_any)                          state_n = S_IDLE;
                else if (cnt == 32'(gap_q) - 32'd1)     state_n = S_GEN;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 32'd1;
            done  <= (state != S_IDLE) && (state_n == S_IDLE);
        end
    end

    // ---------------- run configuration and pattern state ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q        <= '0;
            pattern_q     <= '0;
            beats_q       <= LEN_W'(1);
            count_q       <= '0;
            gap_q         <= '0;
            keep_q        <= '1;
            lfsr          <= SEED;
            beat_idx      <= '0;
            walk_pos      <= '0;
            beat_in_pkt   <= '0;
            packets_sent  <= '0;
            errs_injected <= '0;
        end else if (start_acc) begin
            mode_q        <= mode;
            pattern_q     <= PATTERN;
            beats_q       <= (BEATS_PER_PACKET == '0) ? LEN_W'(1) : BEATS_PER_PACKET;
            count_q       <= PACKET_COUNT;
            gap_q         <= GAP_CYCLES;
            keep_q        <= (LAST_KEEP == '0) ? '1 : LAST_KEEP;
            lfsr          <= SEED;
            beat_idx      <= '0;
            walk_pos      <= '0;
            beat_in_pkt   <= '0;
            packets_sent  <= '0;
            errs_injected <= '0;
        end else if (hs) begin
            lfsr        <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
            beat_idx    <= beat_idx + 32'd1;
            walk_pos    <= (walk_pos == WB'(DW - 1)) ? '0 : walk_pos + WB'(1);
            beat_in_pkt <= last_beat ? '0 : beat_in_pkt + LEN_W'(1);
            if (last_beat && packets_sent != '1)
                packets_sent <= packets_sent + 64'd1;
            if (err_pend)
                errs_injected <= errs_injected + 32'd1;
        end
    end

    // ---------------- abort and error-injection flags ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            abort_pend <= 1'b0;
        end else if (state_n == S_IDLE) begin
            abort_pend <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            abort_pend <= 1'b1;
        end
    end

    // Later assignments win: a sim_err on a clearing handshake re-arms the flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_pend  <= 1'b0;
            err_bit_q <= '0;
        end else begin
            if (start_acc)      err_pend <= 1'b0;
            if (hs && err_pend) err_pend <= 1'b0;
            if (sim_err) begin
                err_pend  <= 1'b1;
                err_bit_q <= err_bit;
            end
        end
    end

    // ---------------- data path ----------------
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        packet_gen_mp_lane #(
            .LANE(g), .NUM_LANES(NUM_LANES), .WB(WB)
        ) u_lane (
            .mode     (mode_q),
            .lfsr     (lfsr),
            .beat_idx (beat_idx),
            .pattern  (pattern_q),
            .walk_pos (walk_pos),
            .word     (lane_word[g])
        );
    end

    assign clean = lane_word;
    assign flip  = (err_pend && tvalid) ? (ONE << err_bit_q) : '0;

    assign AXIS_OUT_TDATA   = in_gen ? (clean ^ flip) : '0;
    assign AXIS_OUT_TLAST   = last_beat;
    assign AXIS_OUT_TKEEP   = last_beat ? keep_q : '1;
    assign AXIS_OUT_TVALID  = tvalid;
    assign AXIS_FIFO_TDATA  = in_gen ? clean : '0;
    assign AXIS_FIFO_TVALID = hs;

    assign packet_sent = hs_last;
    assign busy        = start | (state != S_IDLE);
    assign resetn_fifo = (state != S_FIFO_RST);
endmodule

// File: tb/tb_packet_gen_mp.sv
// Bench for packet_gen_mp: directed runs plus a per-cycle reference model.
module tb_packet_gen_mp;
    localparam int          DW   = 512;
    localparam int          KW   = DW / 8;
    localparam int          NL   = DW / 32;
    localparam int          WB   = $clog2(DW);
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic clk, resetn, start, abort, sim_err;
    logic [1:0] mode;
    logic [31:0] PATTERN;
    logic [15:0] BEATS_PER_PACKET;
    logic [63:0] PACKET_COUNT;
    logic [7:0]  GAP_CYCLES;
    logic [KW-1:0] LAST_KEEP;
    logic [WB-1:0] err_bit;
    logic busy, packet_sent, done, resetn_fifo;
    logic [63:0] packets_sent;
    logic [31:0] errs_injected;
    logic [DW-1:0] AXIS_OUT_TDATA, AXIS_FIFO_TDATA;
    logic [KW-1:0] AXIS_OUT_TKEEP;
    logic AXIS_OUT_TLAST, AXIS_OUT_TVALID, AXIS_OUT_TREADY;
    logic AXIS_FIFO_TVALID, AXIS_FIFO_TREADY;

    packet_gen_mp dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort), .mode(mode),
        .PATTERN(PATTERN), .BEATS_PER_PACKET(BEATS_PER_PACKET),
        .PACKET_COUNT(PACKET_COUNT), .GAP_CYCLES(GAP_CYCLES), .LAST_KEEP(LAST_KEEP),
        .sim_err(sim_err), .err_bit(err_bit), .busy(busy), .packet_sent(packet_sent),
        .done(done), .packets_sent(packets_sent), .errs_injected(errs_injected),
        .resetn_fifo(resetn_fifo), .AXIS_OUT_TDATA(AXIS_OUT_TDATA),
        .AXIS_OUT_TKEEP(AXIS_OUT_TKEEP), .AXIS_OUT_TLAST(AXIS_OUT_TLAST),
        .AXIS_OUT_TVALID(AXIS_OUT_TVALID), .AXIS_OUT_TREADY(AXIS_OUT_TREADY),
        .AXIS_FIFO_TDATA(AXIS_FIFO_TDATA), .AXIS_FIFO_TVALID(AXIS_FIFO_TVALID),
        .AXIS_FIFO_TREADY(AXIS_FIFO_TREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'd0);
    endfunction

    function automatic logic [DW-1:0] exp_word(input logic [1:0] md, input int unsigned n,
                                               input logic [31:0] lf, input logic [31:0] pat);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < NL; i++) begin
            case (md)
                2'd0: w[32*i +: 32] = lf ^ (32'(i) * 32'h9E37_79B9);
                2'd1: w[32*i +: 32] = 32'(n * 32'(NL) + 32'(i));
                2'd2: w[32*i +: 32] = pat;
                default: ;
            endcase
        end
        if (md == 2'd3) w[n % DW] = 1'b1;
        return w;
    endfunction

    logic [1:0]    m_mode = '0;
    logic [31:0]   m_pat = '0;
    int unsigned   m_beats = 1;
    logic [KW-1:0] m_keep = '1;
    int unsigned   m_n = 0;
    logic [31:0]   m_lfsr = SEED;
    bit            m_pend = 0;
    logic [WB-1:0] m_bit = '0;
    logic [63:0]   m_pkts = '0;
    logic [31:0]   m_errs = '0;
    logic [DW-1:0] m_clean, m_mask;
    bit            m_hs, m_tl;

    always @(negedge clk) begin
        if (!resetn) begin
            m_pkts = '0; m_errs = '0; m_pend = 0;
        end else begin
            m_hs = AXIS_OUT_TVALID & AXIS_OUT_TREADY;
            m_tl = ((m_n % m_beats) == m_beats - 1);
            chk("fifo_valid", 64'(AXIS_FIFO_TVALID), 64'(m_hs));
            chk("packet_sent", 64'(packet_sent), 64'(m_hs & m_tl));
            chk("packets_sent", packets_sent, m_pkts);
            chk("errs_injected", 64'(errs_injected), 64'(m_errs));
            if (AXIS_OUT_TVALID) begin
                m_clean = exp_word(m_mode, m_n, m_lfsr, m_pat);
                m_mask  = '0;
                if (m_pend) m_mask[m_bit] = 1'b1;
                chk("valid_needs_fifo_ready", 64'(AXIS_FIFO_TREADY), 64'd1);
                chkw("out_tdata", AXIS_OUT_TDATA, m_clean ^ m_mask);
                chk("out_tlast", 64'(AXIS_OUT_TLAST), 64'(m_tl));
                chk("out_tkeep", 64'(AXIS_OUT_TKEEP), m_tl ? 64'(m_keep) : 64'hFFFF_FFFF_FFFF_FFFF);
                if (m_hs) chkw("fifo_tdata", AXIS_FIFO_TDATA, m_clean);
            end
            if (m_hs) begin
                if (m_pend) begin m_errs++; m_pend = 0; end
                if (m_tl) m_pkts++;
                m_n++;
                m_lfsr = lfsr_step(m_lfsr);
            end
            if (start) begin
                m_mode = mode; m_pat = PATTERN;
                m_beats = (BEATS_PER_PACKET == 0) ? 1 : int'(BEATS_PER_PACKET);
                m_keep = (LAST_KEEP == '0) ? '1 : LAST_KEEP;
                m_n = 0; m_lfsr = SEED; m_pend = 0; m_pkts = '0; m_errs = '0;
            end
            if (sim_err) begin m_pend = 1; m_bit = err_bit; end
        end
    end

    // ---------------- run observation ----------------
    int w_beats, w_pkts, w_done, w_done_cyc, w_last_hs, w_rst_low, w_tlast;
    int w_gaps[$];
    int w_tl_idx[$];
    logic [31:0]   w_lane0[$];
    logic [31:0]   w_lane1[$];
    logic [KW-1:0] w_keep[$];
    logic [DW-1:0] w_xor[$];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [1:0] md, input int beats, input longint cnt,
                            input int gap, input logic [KW-1:0] lk);
        mode = md; BEATS_PER_PACKET = 16'(beats); PACKET_COUNT = 64'(cnt);
        GAP_CYCLES = 8'(gap); LAST_KEEP = lk; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Samples each cycle at posedge+2 until done is seen or the bound expires.
    task automatic watch(input int bound, input bit rnd, input int abort_beat);
        int c = 0;
        bit seen = 0;
        bit in_gap = 0;
        int gap_start = 0;
        w_beats = 0; w_pkts = 0; w_done = 0; w_done_cyc = -1; w_last_hs = -1;
        w_rst_low = 0; w_tlast = 0;
        w_gaps.delete(); w_tl_idx.delete(); w_lane0.delete(); w_lane1.delete();
        w_keep.delete(); w_xor.delete();
        while (!seen && c < bound) begin
            #1;
            if (!resetn_fifo) w_rst_low++;
            if (packet_sent) w_pkts++;
            if (done) begin w_done++; w_done_cyc = c; seen = 1; end
            if (AXIS_OUT_TVALID && in_gap) begin
                w_gaps.push_back(c - gap_start - 1); in_gap = 0;
            end
            if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
                w_lane0.push_back(AXIS_OUT_TDATA[31:0]);
                w_lane1.push_back(AXIS_OUT_TDATA[63:32]);
                w_keep.push_back(AXIS_OUT_TKEEP);
                w_xor.push_back(AXIS_OUT_TDATA ^ AXIS_FIFO_TDATA);
                if (AXIS_OUT_TLAST) begin
                    w_tlast++; w_tl_idx.push_back(w_beats); gap_start = c; in_gap = 1;
                end
                if (w_beats == abort_beat) abort = 1'b1;
                w_beats++; w_last_hs = c;
            end
            c++;
            @(posedge clk); #1;
            abort = 1'b0;
            if (rnd) begin
                AXIS_OUT_TREADY  = 1'($urandom_range(0, 1));
                AXIS_FIFO_TREADY = 1'($urandom_range(0, 1));
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done within %0d cycles", bound);
        end
        AXIS_OUT_TREADY = 1'b1; AXIS_FIFO_TREADY = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tvalid"}, 64'(AXIS_OUT_TVALID), 64'd0);
        chk({tag, "_tlast"}, 64'(AXIS_OUT_TLAST), 64'd0);
        chk({tag, "_tkeep"}, 64'(AXIS_OUT_TKEEP), 64'hFFFF_FFFF_FFFF_FFFF);
        chkw({tag, "_tdata"}, AXIS_OUT_TDATA, '0);
        chkw({tag, "_fifo_tdata"}, AXIS_FIFO_TDATA, '0);
        chk({tag, "_fifo_tvalid"}, 64'(AXIS_FIFO_TVALID), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_packet_sent"}, 64'(packet_sent), 64'd0);
        chk({tag, "_packets_sent"}, packets_sent, 64'd0);
        chk({tag, "_errs"}, 64'(errs_injected), 64'd0);
        chk({tag, "_resetn_fifo"}, 64'(resetn_fifo), 64'd1);
    endtask

    logic [DW-1:0] e300;

    initial begin
        resetn = 1'b0; start = 0; abort = 0; sim_err = 0; mode = 0; PATTERN = 0;
        BEATS_PER_PACKET = 0; PACKET_COUNT = 0; GAP_CYCLES = 0; LAST_KEEP = 0;
        err_bit = 0; AXIS_OUT_TREADY = 1; AXIS_FIFO_TREADY = 1;
        #12;
        check_reset_vals("reset");
        tick(); resetn = 1'b1; tick();

        // Counter pattern: 3 packets of 4 beats back to back.
        do_start(2'd1, 4, 3, 0, '0);
        watch(200, 0, -1);
        chk("t1_beats", 64'(w_beats), 64'd12);
        chk("t1_pkts", 64'(w_pkts), 64'd3);
        chk("t1_rst_low", 64'(w_rst_low), 64'd16);
        chk("t1_done_after_last", 64'(w_done_cyc - w_last_hs), 64'd1);
        for (int k = 0; k < 12 && k < w_lane0.size(); k++)
            chk("t1_lane0", 64'(w_lane0[k]), 64'(16 * k));
        if (w_lane0.size() == 12) chk("t1_lane0_b11", 64'(w_lane0[11]), 64'd176);
        if (w_tl_idx.size() == 3) begin
            chk("t1_tlast0", 64'(w_tl_idx[0]), 64'd3);
            chk("t1_tlast1", 64'(w_tl_idx[1]), 64'd7);
            chk("t1_tlast2", 64'(w_tl_idx[2]), 64'd11);
        end else chk("t1_tlast_count", 64'(w_tl_idx.size()), 64'd3);
        tick();
        chk("t1_done_one_cycle", 64'(done), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);
        chk("t1_packets_sent", packets_sent, 64'd3);

        // LFSR pattern under random backpressure on both sides.
        do_start(2'd0, 2, 2, 0, '0);
        watch(600, 1, -1);
        chk("t2_beats", 64'(w_beats), 64'd4);
        if (w_lane0.size() == 4) begin
            chk("t2_b0_lane0", 64'(w_lane0[0]), 64'hACE1_2468);
            chk("t2_b0_lane1", 64'(w_lane1[0]), 64'h32D6_5DD1);
            chk("t2_b1_lane0", 64'(w_lane0[1]), 64'h5670_9234);
            chk("t2_b2_lane0", 64'(w_lane0[2]), 64'h2B38_491A);
            chk("t2_b3_lane0", 64'(w_lane0[3]), 64'h159C_248D);
            for (int k = 0; k < 4; k++) chkw("t2_mirror", w_xor[k], '0);
        end
        tick();

        // Single-bit error requested while the compare FIFO is in reset.
        do_start(2'd1, 2, 2, 0, '0);
        tick(); tick();
        err_bit = 9'd300; sim_err = 1'b1;
        tick();
        sim_err = 1'b0;
        watch(200, 0, -1);
        e300 = '0; e300[300] = 1'b1;
        chk("t3_beats", 64'(w_beats), 64'd4);
        if (w_xor.size() == 4) begin
            chkw("t3_first_flip", w_xor[0], e300);
            for (int k = 1; k < 4; k++) chkw("t3_later_clean", w_xor[k], '0);
        end
        chk("t3_errs", 64'(errs_injected), 64'd1);
        tick();

        // Continuous run with gaps, aborted on the second beat of packet 4.
        PATTERN = 32'hDEAD_BEEF;
        do_start(2'd2, 3, 0, 5, '0);
        watch(400, 0, 10);
        chk("t4_beats", 64'(w_beats), 64'd12);
        chk("t4_pkts", 64'(w_pkts), 64'd4);
        chk("t4_packets_sent", packets_sent, 64'd4);
        chk("t4_gap_count", 64'(w_gaps.size()), 64'd3);
        foreach (w_gaps[k]) chk("t4_gap_len", 64'(w_gaps[k]), 64'd5);
        if (w_lane0.size() > 0) chk("t4_pattern", 64'(w_lane0[0]), 64'hDEAD_BEEF);
        tick();
        chk("t4_idle", 64'(busy), 64'd0);

        // Single-beat packets with a partial last keep, walking-one data.
        do_start(2'd3, 1, 3, 0, 64'h0000_0000_0000_00FF);
        watch(200, 0, -1);
        chk("t5_beats", 64'(w_beats), 64'd3);
        chk("t5_tlast", 64'(w_tlast), 64'd3);
        if (w_lane0.size() == 3) begin
            chk("t5_keep", 64'(w_keep[0]), 64'hFF);
            chk("t5_walk0", 64'(w_lane0[0]), 64'd1);
            chk("t5_walk2", 64'(w_lane0[2]), 64'd4);
        end
        tick();
        // BEATS=0 behaves as one beat; LAST_KEEP=0 behaves as all-ones.
        do_start(2'd1, 0, 2, 0, '0);
        watch(200, 0, -1);
        chk("t5b_beats", 64'(w_beats), 64'd2);
        chk("t5b_tlast", 64'(w_tlast), 64'd2);
        if (w_keep.size() == 2) chk("t5b_keep", 64'(w_keep[1]), 64'hFFFF_FFFF_FFFF_FFFF);
        tick();

        // Asynchronous reset in the middle of a continuous run.
        do_start(2'd1, 4, 0, 0, '0);
        repeat (41) tick();
        chk("t6_running", 64'(AXIS_OUT_TVALID), 64'd1);
        resetn = 1'b0;
        #1;
        check_reset_vals("midreset");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_done_in_reset", 64'(done), 64'd0);
        end
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_done_after", 64'(done), 64'd0);
        end
        do_start(2'd1, 2, 1, 0, '0);
        watch(200, 0, -1);
        chk("t6_rst_low", 64'(w_rst_low), 64'd16);
        chk("t6_beats", 64'(w_beats), 64'd2);
        if (w_lane0.size() == 2) begin
            chk("t6_restart_lane0", 64'(w_lane0[0]), 64'd0);
            chk("t6_restart_lane1", 64'(w_lane1[1]), 64'd17);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/packet_gen_mp.md
Name: packet_gen_mp

Overview:
- Parametrised multi-pattern packet generator for the cable loopback test.
- Drives AXI-Stream packets of configurable length, pattern, inter-packet gap and last-beat TKEEP onto the cable path.
- Mirrors every transmitted beat, without any injected error, into a compare-FIFO stream.
- Adds deterministic error injection, continuous mode, graceful abort and status counters.

Parameters:
- DW, 512: TDATA width in bits; multiple of 32, 64..1024.
- LEN_W, 16: width of beats-per-packet input.
- GAP_W, 8: width of inter-packet idle-gap input.
- RST_CYC, 16: cycles resetn_fifo is held low, and then the settle cycles after release.
- SEED, 32'hACE1_2468: LFSR load value at each start; must be non-zero.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous and active-low.
- start  in  1  pulse; begins a run when idle, ignored otherwise.
- abort  in  1  pulse; ends the run after the current packet.
- mode  in  2  sampled at start: 0 LFSR, 1 counter, 2 fixed PATTERN, 3 walking-one.
- PATTERN  in  32  lane value for mode 2.
- BEATS_PER_PACKET  in  LEN_W  beats per packet; 0 is treated as 1.
- PACKET_COUNT  in  64  packets per run; 0 means continuous until abort.
- GAP_CYCLES  in  GAP_W  idle cycles between packets.
- LAST_KEEP  in  DW/8  TKEEP on the last beat (all other beats all-ones); 0 is treated as all-ones.
- sim_err  in  1  pulse; requests a single-bit error.
- err_bit  in  log2(DW)  bit index to flip, sampled with sim_err.
- busy  out  1  start OR state != IDLE.
- packet_sent  out  1  strobe on last-beat handshake.
- done  out  1  one-cycle strobe on return to IDLE.
- packets_sent  out  64  count of completed packets this run.
- errs_injected  out  32  count of corrupted beats this run.
- resetn_fifo  out  1  compare-FIFO reset, active-low.
- AXIS_OUT_TDATA/TKEEP/TLAST/TVALID  out  DW/DW/8/1/1;  AXIS_OUT_TREADY  in  1.
- AXIS_FIFO_TDATA/TVALID  out  DW/1;  AXIS_FIFO_TREADY  in  1.

Behaviour:
Reset values:
- All outputs 0 except resetn_fifo=1 and TKEEP all-ones.
- State IDLE, counters 0, LFSR=SEED.

States and transitions:
- IDLE -> FIFO_RST on start.
  - Action: latch mode, PATTERN, BEATS, COUNT, GAP, LAST_KEEP.
  - Action: clear packets_sent, errs_injected and the pending error.
  - Action: load LFSR=SEED; drive resetn_fifo=0.
- FIFO_RST -> FIFO_SETTLE after RST_CYC cycles; resetn_fifo=1.
- FIFO_SETTLE -> GEN after RST_CYC cycles.
- GEN, on last-beat handshake:
  - -> IDLE if abort is pending, or COUNT!=0 and packets_sent+1==COUNT.
  - else -> GAP if GAP!=0.
  - else stays in GEN.
- GAP -> GEN after GAP cycles; exits to IDLE if abort is pending.

Handshake and data rules:
- TVALID = (state==GEN) & AXIS_FIFO_TREADY. A full compare FIFO stalls transmission; no beat is ever lost from the mirror.
- Handshake = TVALID & TREADY. AXIS_FIFO_TVALID = handshake; FIFO TDATA = clean data.
- TDATA, TKEEP and TLAST are held stable while TVALID=1 and TREADY=0. The pattern advances only on handshake.
- beat_idx (32-bit) resets to 0 at start and increments per handshake across packets.

Patterns, lane i = bits [32i+31:32i]:
- Mode 0: lfsr ^ (i*32'h9E3779B9), mod 2^32. The LFSR is a 32-bit Galois right-shift, taps 32'h80200003, stepped per handshake.
- Mode 1: beat_idx*(DW/32)+i, mod 2^32.
- Mode 2: PATTERN.
- Mode 3: the whole word is a single 1 at bit (beat_idx mod DW).

TLAST:
- TLAST = GEN & (beat_in_pkt == BEATS-1).
- TKEEP = LAST_KEEP on the TLAST beat, otherwise all-ones.

Error injection:
- sim_err in any state sets the pending flag and latches err_bit.
- The next beat presented with TVALID=1 has bit err_bit inverted on AXIS_OUT only.
- The flag clears on that beat's handshake, and errs_injected increments.
- A new sim_err while an error is pending overwrites err_bit; only one error is produced.
- sim_err on the same cycle as a clearing handshake re-arms the flag.

Abort:
- An abort pulse is latched until IDLE is reached; abort in IDLE is ignored.
- Abort never truncates a packet.

Status outputs:
- packets_sent saturates at 2^64-1.
- done pulses on the cycle state becomes IDLE; never on reset.
- start while busy is ignored.

Asynchronous reset mid-run:
- Immediate return to IDLE with TVALID=0 and resetn_fifo=1.
- No done pulse.

Test Plan:
- Mode 1, DW=512, BEATS=4, COUNT=3, GAP=0, TREADY=1 -> 12 beats, lane0 values 0,16,32..176; TLAST on beats 3,7,11; packet_sent x3; done 1 cycle after beat 11.
- Mode 0, BEATS=2, COUNT=2, random TREADY and FIFO_TREADY backpressure -> beats match the LFSR reference model from SEED; data held stable while stalled; FIFO stream identical to OUT.
- sim_err with err_bit=300 during FIFO_RST -> first GEN beat differs from its FIFO copy only in bit 300; errs_injected=1; later beats clean.
- COUNT=0, GAP=5, BEATS=3, abort on the second beat of packet 4 -> packet 4 completes; exactly 5 idle cycles between packets; packets_sent=4; then IDLE.
- LAST_KEEP=64'h0000_0000_0000_00FF, BEATS=1 -> every beat has TLAST=1 and TKEEP=0xFF; BEATS=0 behaves as 1.
- Assert resetn low mid-packet, then start again -> outputs at reset values; the new run restarts the pattern from SEED/beat 0, and resetn_fifo is low for 16 cycles.
